// File: rtl/decod_morse_pkg.sv
// Shared FSM state type, code constants and the Morse code table used by
// both the decoder and the encoder.
package decod_morse_pkg;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  localparam logic [5:0]  NUM_INVALID = 6'd63;
  localparam logic [5:0]  NUM_A       = 6'd10;
  localparam int unsigned NUM_CODES   = 36;

  // morse: first symbol at bit 4, 1 = traco; display: left-aligned length mask
  typedef struct packed {
    logic [4:0] morse;
    logic [4:0] display;
  } code_t;

  function automatic code_t morse_code(input logic [5:0] n);
    case (n)
      6'd0:  morse_code = '{5'b11111, 5'b11111};
      6'd1:  morse_code = '{5'b01111, 5'b11111};
      6'd2:  morse_code = '{5'b00111, 5'b11111};
      6'd3:  morse_code = '{5'b00011, 5'b11111};
      6'd4:  morse_code = '{5'b00001, 5'b11111};
      6'd5:  morse_code = '{5'b00000, 5'b11111};
      6'd6:  morse_code = '{5'b10000, 5'b11111};
      6'd7:  morse_code = '{5'b11000, 5'b11111};
      6'd8:  morse_code = '{5'b11100, 5'b11111};
      6'd9:  morse_code = '{5'b11110, 5'b11111};
      6'd10: morse_code = '{5'b01000, 5'b11000};  // A
      6'd11: morse_code = '{5'b10000, 5'b11110};
      6'd12: morse_code = '{5'b10100, 5'b11110};
      6'd13: morse_code = '{5'b10000, 5'b11100};
      6'd14: morse_code = '{5'b00000, 5'b10000};
      6'd15: morse_code = '{5'b00100, 5'b11110};
      6'd16: morse_code = '{5'b11000, 5'b11100};
      6'd17: morse_code = '{5'b00000, 5'b11110};
      6'd18: morse_code = '{5'b00000, 5'b11000};
      6'd19: morse_code = '{5'b01110, 5'b11110};
      6'd20: morse_code = '{5'b10100, 5'b11100};
      6'd21: morse_code = '{5'b01000, 5'b11110};
      6'd22: morse_code = '{5'b11000, 5'b11000};
      6'd23: morse_code = '{5'b10000, 5'b11000};
      6'd24: morse_code = '{5'b11100, 5'b11100};
      6'd25: morse_code = '{5'b01100, 5'b11110};
      6'd26: morse_code = '{5'b11010, 5'b11110};
      6'd27: morse_code = '{5'b01000, 5'b11100};
      6'd28: morse_code = '{5'b00000, 5'b11100};
      6'd29: morse_code = '{5'b10000, 5'b10000};
      6'd30: morse_code = '{5'b00100, 5'b11100};
      6'd31: morse_code = '{5'b00010, 5'b11110};
      6'd32: morse_code = '{5'b01100, 5'b11100};
      6'd33: morse_code = '{5'b10010, 5'b11110};
      6'd34: morse_code = '{5'b10110, 5'b11110};
      6'd35: morse_code = '{5'b11000, 5'b11110};
      default: morse_code = '{'0, '0};
    endcase
  endfunction

  // Decoding is a search over the encoder table, so the two cannot diverge.
  function automatic logic [5:0] morse_decode(input logic [4:0] morse,
                                              input logic [4:0] display);
    morse_decode = NUM_INVALID;
    for (int unsigned i = 0; i < NUM_CODES; i++) begin
      if (morse_code(6'(i)) == {morse, display})
        morse_decode = 6'(i);
    end
  endfunction

endpackage

// File: rtl/morse_key_sync.sv
// Two-flop synchronizer for the key input; DECOD_MORSE_DEBOUNCE_EN adds a
// filter that only passes a level seen on three consecutive samples.
module morse_key_sync (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic ks
);

  logic s1, s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

`ifdef DECOD_MORSE_DEBOUNCE_EN
  logic s3, s4, held;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s3   <= 1'b0;
      s4   <= 1'b0;
      held <= 1'b0;
    end else begin
      s3   <= s2;
      s4   <= s3;
      held <= ks;
    end
  end

  always_comb ks = (s2 == s3 && s3 == s4) ? s2 : held;
`else
  always_comb ks = s2;
`endif

endmodule

// File: rtl/decod_morse.sv
// Morse key decoder: classifies marks as ponto/traco, collects up to five
// symbols and emits a character code after a long space.
module decod_morse
  import decod_morse_pkg::*;
#(
  parameter int unsigned DOT_MAX  = 4,
  parameter int unsigned GAP_CHAR = 10,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic       ready,
  output logic [5:0] num,
  output logic [4:0] morse,
  output logic [4:0] display,
  output logic       error
);

  logic             ks;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [4:0]       sh_morse, sh_disp;
  logic [2:0]       nsym;
  logic             ovf, append, clear, is_dash, emit, bad;
  logic [5:0]       dec_num;

  morse_key_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .ks    (ks)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    append   = 1'b0;
    clear    = 1'b0;
    case (state)
      IDLE: if (ks) begin
        state_nx = MARK;
        cnt_nx   = CNT_W'(1);
      end
      MARK: if (!ks) begin
        append   = 1'b1;
        state_nx = SPACE;
        cnt_nx   = CNT_W'(1);
      end else if (cnt != '1) begin
        cnt_nx = cnt + CNT_W'(1);
      end
      // the gap check wins over a new mark arriving on the same cycle
      SPACE: if (cnt >= CNT_W'(GAP_CHAR)) begin
        state_nx = EMIT;
      end else if (ks) begin
        state_nx = MARK;
        cnt_nx   = CNT_W'(1);
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
      EMIT: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        clear    = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb is_dash = (cnt > CNT_W'(DOT_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      sh_morse <= '0;
      sh_disp  <= '0;
      nsym     <= '0;
      ovf      <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      if (clear) begin
        sh_morse <= '0;
        sh_disp  <= '0;
        nsym     <= '0;
        ovf      <= 1'b0;
      end else if (append) begin
        if (nsym == 3'd5) begin
          ovf <= 1'b1;
        end else begin
          sh_morse[3'd4 - nsym] <= is_dash;
          sh_disp[3'd4 - nsym]  <= 1'b1;
          nsym                  <= nsym + 3'd1;
        end
      end
    end
  end

  always_comb begin
    emit    = (state == EMIT);
    dec_num = morse_decode(sh_morse, sh_disp);
    bad     = ovf || (dec_num == NUM_INVALID);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready   <= 1'b0;
      num     <= '0;
      morse   <= '0;
      display <= '0;
      error   <= 1'b0;
    end else begin
      ready <= emit;
      if (emit) begin
        num     <= bad ? NUM_INVALID : dec_num;
        error   <= bad;
        morse   <= sh_morse;
        display <= sh_disp;
      end
    end
  end

endmodule

// File: tb/tb_decod_morse.sv
// Directed bench for decod_morse with default parameters (DOT_MAX=4, GAP_CHAR=10).
module tb_decod_morse;

  localparam int GAP_CHAR = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key = 1'b0;
  logic       ready;
  logic [5:0] num;
  logic [4:0] morse;
  logic [4:0] display;
  logic       error;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rdy_n = 0;
  int rdy_cyc = 0;
  logic [5:0] cap_num;
  logic [4:0] cap_morse, cap_disp;
  logic       cap_err;

  decod_morse #(.DOT_MAX(4), .GAP_CHAR(GAP_CHAR), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .key     (key),
    .ready   (ready),
    .num     (num),
    .morse   (morse),
    .display (display),
    .error   (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready) begin
      rdy_n     = rdy_n + 1;
      rdy_cyc   = cyc;
      cap_num   = num;
      cap_morse = morse;
      cap_disp  = display;
      cap_err   = error;
    end
  end

  task automatic hold(input logic v, input int n);
    key = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mark_space(input int m, input int s);
    hold(1'b1, m);
    hold(1'b0, s);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hold(1'b0, 3);
    vectors++;
    if ({ready, error, num, morse, display} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b err=%b num=%0d morse=%b disp=%b, want all zero",
               ready, error, num, morse, display);
    end
    reset = 1'b1;
    hold(1'b0, 2);
  endtask

  task automatic test_letter_a();
    int base, fall;
    base = rdy_n;
    mark_space(2, 2);
    hold(1'b1, 6);
    fall = cyc;
    hold(1'b0, 20);
    vectors++;
    if (rdy_n - base !== 1 || cap_num !== 6'd10 || cap_morse !== 5'b01000 ||
        cap_disp !== 5'b11000 || cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL letter_a: got pulses=%0d num=%0d morse=%b disp=%b err=%b, want 1 10 01000 11000 0",
               rdy_n - base, cap_num, cap_morse, cap_disp, cap_err);
    end
    // key is driven just after edge 'fall' and first sampled on the next edge
    vectors++;
    if (rdy_cyc - fall !== GAP_CHAR + 3 + 1) begin
      miscompares++;
      $display("FAIL latency: got %0d cycles, want %0d", rdy_cyc - fall - 1, GAP_CHAR + 3);
    end
  endtask

  task automatic test_digit_zero();
    int base;
    base = rdy_n;
    repeat (4) mark_space(6, 2);
    mark_space(6, 20);
    vectors++;
    if (rdy_n - base !== 1 || cap_num !== 6'd0 || cap_morse !== 5'b11111 ||
        cap_disp !== 5'b11111 || cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL digit_zero: got pulses=%0d num=%0d morse=%b disp=%b err=%b, want 1 0 11111 11111 0",
               rdy_n - base, cap_num, cap_morse, cap_disp, cap_err);
    end
  endtask

  task automatic test_overflow();
    int base;
    base = rdy_n;
    repeat (5) mark_space(2, 2);
    mark_space(2, 20);
    vectors++;
    if (rdy_n - base !== 1 || cap_num !== 6'd63 || cap_morse !== 5'b00000 ||
        cap_disp !== 5'b11111 || cap_err !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: got pulses=%0d num=%0d morse=%b disp=%b err=%b, want 1 63 00000 11111 1",
               rdy_n - base, cap_num, cap_morse, cap_disp, cap_err);
    end
  endtask

  task automatic test_unmatched();
    int base;
    base = rdy_n;
    mark_space(2, 2);
    mark_space(2, 2);
    mark_space(6, 2);
    mark_space(6, 20);
    vectors++;
    if (rdy_n - base !== 1 || cap_num !== 6'd63 || cap_morse !== 5'b00110 ||
        cap_disp !== 5'b11110 || cap_err !== 1'b1) begin
      miscompares++;
      $display("FAIL unmatched: got pulses=%0d num=%0d morse=%b disp=%b err=%b, want 1 63 00110 11110 1",
               rdy_n - base, cap_num, cap_morse, cap_disp, cap_err);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = rdy_n;
    mark_space(1, 20);
    vectors++;
    if (rdy_n - base !== 1 || cap_num !== 6'd14 || cap_morse !== 5'b00000 ||
        cap_disp !== 5'b10000 || cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_e: got pulses=%0d num=%0d morse=%b disp=%b err=%b, want 1 14 00000 10000 0",
               rdy_n - base, cap_num, cap_morse, cap_disp, cap_err);
    end
    mark_space(8, 20);
    vectors++;
    if (rdy_n - base !== 2 || cap_num !== 6'd29 || cap_morse !== 5'b10000 ||
        cap_disp !== 5'b10000 || cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_t: got pulses=%0d num=%0d morse=%b disp=%b err=%b, want 2 29 10000 10000 0",
               rdy_n - base, cap_num, cap_morse, cap_disp, cap_err);
    end
  endtask

  task automatic test_dot_max();
    int base;
    base = rdy_n;
    mark_space(4, 20);
    vectors++;
    if (rdy_n - base !== 1 || cap_num !== 6'd14 || cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL dot_max_4: got pulses=%0d num=%0d err=%b, want 1 14 0",
               rdy_n - base, cap_num, cap_err);
    end
    mark_space(5, 20);
    vectors++;
    if (rdy_n - base !== 2 || cap_num !== 6'd29 || cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL dot_max_5: got pulses=%0d num=%0d err=%b, want 2 29 0",
               rdy_n - base, cap_num, cap_err);
    end
  endtask

  task automatic test_saturation();
    int base;
    base = rdy_n;
    hold(1'b1, 300);
    vectors++;
    if (rdy_n - base !== 0) begin
      miscompares++;
      $display("FAIL sat_no_emit: got %0d pulses during long mark, want 0", rdy_n - base);
    end
    hold(1'b0, 20);
    vectors++;
    if (rdy_n - base !== 1 || cap_num !== 6'd29 || cap_morse !== 5'b10000 || cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_decode: got pulses=%0d num=%0d morse=%b err=%b, want 1 29 10000 0",
               rdy_n - base, cap_num, cap_morse, cap_err);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = rdy_n;
    mark_space(2, 2);
    hold(1'b1, 6);
    key   = 1'b0;
    reset = 1'b0;
    hold(1'b0, 1);
    reset = 1'b1;
    hold(1'b0, 20);
    vectors++;
    if (rdy_n - base !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_ready: got %0d pulses, want 0", rdy_n - base);
    end
    vectors++;
    if ({ready, error, num, morse, display} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_mid_outs: got err=%b num=%0d morse=%b disp=%b, want all zero",
               error, num, morse, display);
    end
  endtask

  task automatic test_held_through_reset();
    int base;
    base  = rdy_n;
    reset = 1'b0;
    hold(1'b1, 2);
    reset = 1'b1;
    hold(1'b1, 1);
    hold(1'b0, 20);
    vectors++;
    if (rdy_n - base !== 1 || cap_num !== 6'd14 || cap_disp !== 5'b10000 || cap_err !== 1'b0) begin
      miscompares++;
      $display("FAIL held_reset: got pulses=%0d num=%0d disp=%b err=%b, want 1 14 10000 0",
               rdy_n - base, cap_num, cap_disp, cap_err);
    end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_digit_zero();
    test_overflow();
    test_unmatched();
    test_back_to_back();
    test_dot_max();
    test_saturation();
    test_reset_mid();
    test_held_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
